debounce_count_ctrl: RTL and testbench

DEBOUNCE_COUNT_CTRL -- requirements
Module: debounce_count_ctrl

---
 rtl/dsd_ctrl_pkg.sv | 13 +
 rtl/tick_gen.sv | 28 ++
 rtl/debounce_count_ctrl.sv | 142 ++++++++++++++
 tb/tb_debounce_count_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dsd_ctrl_pkg.sv
// Shared definitions for the debounce/count controller: FSM encoding and counter width.
package dsd_ctrl_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } state_e;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/tick_gen.sv
// Sample-tick prescaler: one-cycle tick every DIV cycles, restartable to phase zero.
module tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] r_cnt;

    assign tick = (r_cnt == W'(DIV - 1));

    // Holding restart keeps the prescaler parked at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/debounce_count_ctrl.sv
// Switch debouncer with a rise-check/fall-check FSM, debounced and raw rising-edge counters.
module debounce_count_ctrl
    import dsd_ctrl_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 50000,
    parameter int unsigned STABLE_CNT = 20
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             sw_in,
    input  logic             clr,
    output logic             sw_db,
    output logic             cnt_en,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_raw,
    output logic [1:0]       state
);

    localparam int unsigned STB_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CNT - 1);

    logic             r_sync1;
    logic             r_sw_s;
    logic             r_sw_s_d1;
    state_e           r_state;
    state_e           w_state_d;
    logic [STB_W-1:0] r_stable;
    logic [STB_W-1:0] w_stable_d;
    logic             r_sw_db;
    logic             w_sw_db_d;
    logic             r_cnt_en;
    logic             w_acc_rise;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cnt_raw;
    logic             w_tick;
    logic             w_restart;
    logic             w_in_chk;
    logic             w_raw_rise;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sw_s    <= 1'b0;
            r_sw_s_d1 <= 1'b0;
        end else begin
            r_sync1   <= sw_in;
            r_sw_s    <= r_sync1;
            r_sw_s_d1 <= r_sw_s;
        end
    end

    assign w_in_chk = (r_state == S_RISE_CHK) || (r_state == S_FALL_CHK);
    // Prescaler runs only while remaining in a CHK state; any entry re-phases it.
    assign w_restart = !(w_in_chk && (w_state_d == r_state));

    tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_comb begin
        w_state_d  = r_state;
        w_stable_d = r_stable;
        w_sw_db_d  = r_sw_db;
        w_acc_rise = 1'b0;
        case (r_state)
            S_LOW: begin
                if (r_sw_s) w_state_d = S_RISE_CHK;
            end
            S_HIGH: begin
                if (!r_sw_s) w_state_d = S_FALL_CHK;
            end
            S_RISE_CHK: begin
                if (w_tick) begin
                    if (!r_sw_s) begin
                        w_state_d = S_LOW;
                    end else if (r_stable == STB_LAST) begin
                        w_state_d  = S_HIGH;
                        w_sw_db_d  = 1'b1;
                        w_acc_rise = 1'b1;
                    end else begin
                        w_stable_d = r_stable + 1'b1;
                    end
                end
            end
            S_FALL_CHK: begin
                if (w_tick) begin
                    if (r_sw_s) begin
                        w_state_d = S_HIGH;
                    end else if (r_stable == STB_LAST) begin
                        w_state_d = S_LOW;
                        w_sw_db_d = 1'b0;
                    end else begin
                        w_stable_d = r_stable + 1'b1;
                    end
                end
            end
            default: w_state_d = S_LOW;
        endcase
        if (w_state_d != r_state) w_stable_d = '0;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_LOW;
            r_stable <= '0;
            r_sw_db  <= 1'b0;
            r_cnt_en <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_stable <= w_stable_d;
            r_sw_db  <= w_sw_db_d;
            r_cnt_en <= w_acc_rise;
        end
    end

    assign w_raw_rise = r_sw_s && !r_sw_s_d1;

    // clr wins over a same-cycle increment.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_cnt_raw <= '0;
        end else begin
            if (clr)             r_cnt <= '0;
            else if (w_acc_rise) r_cnt <= r_cnt + 1'b1;
            if (clr)             r_cnt_raw <= '0;
            else if (w_raw_rise) r_cnt_raw <= r_cnt_raw + 1'b1;
        end
    end

    assign sw_db   = r_sw_db;
    assign cnt_en  = r_cnt_en;
    assign cnt     = r_cnt;
    assign cnt_raw = r_cnt_raw;
    assign state   = r_state;

endmodule

// File: tb/tb_debounce_count_ctrl.sv
// Directed bench for debounce_count_ctrl with SAMPLE_DIV=4, STABLE_CNT=3.
module tb_debounce_count_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic       sw_in;
    logic       clr;
    logic       sw_db;
    logic       cnt_en;
    logic [7:0] cnt;
    logic [7:0] cnt_raw;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cycles = 0;

    debounce_count_ctrl #(
        .SAMPLE_DIV (4),
        .STABLE_CNT (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .sw_in    (sw_in),
        .clr      (clr),
        .sw_db    (sw_db),
        .cnt_en   (cnt_en),
        .cnt      (cnt),
        .cnt_raw  (cnt_raw),
        .state    (state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) if (cnt_en === 1'b1) en_cycles++;

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Returns edges elapsed after the first sampling edge, or -1 on timeout.
    task automatic wait_en(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (cnt_en === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw_in = 1'b0;
        clr   = 1'b0;
        #12;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_checks++; if (sw_db !== 1'b0) begin n_fail++; $display("FAIL reset_sw_db got %b want 0", sw_db); end
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en got %b want 0", cnt_en); end
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        n_checks++; if (cnt_raw !== 8'd0) begin n_fail++; $display("FAIL reset_cnt_raw got %0d want 0", cnt_raw); end
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_clean_rise();
        int lat;
        sw_in = 1'b1;
        wait_en(lat);
        n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL rise_latency got %0d want 14", lat); end
        n_checks++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL rise_cnt got %0d want 1", cnt); end
        n_checks++; if (cnt_raw !== 8'd1) begin n_fail++; $display("FAIL rise_cnt_raw got %0d want 1", cnt_raw); end
        n_checks++; if (sw_db !== 1'b1) begin n_fail++; $display("FAIL rise_sw_db got %b want 1", sw_db); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL rise_state got %0d want 2", state); end
        step(1);
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL rise_pulse_width got %b want 0", cnt_en); end
    endtask

    task automatic test_fall();
        int e0;
        e0 = en_cycles;
        sw_in = 1'b0;
        step(20);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL fall_state got %0d want 0", state); end
        n_checks++; if (sw_db !== 1'b0) begin n_fail++; $display("FAIL fall_sw_db got %b want 0", sw_db); end
        n_checks++; if (en_cycles - e0 !== 0) begin n_fail++; $display("FAIL fall_no_pulse got %0d want 0", en_cycles - e0); end
        n_checks++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL fall_cnt got %0d want 1", cnt); end
        pulse_clr();
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL clr_cnt got %0d want 0", cnt); end
        n_checks++; if (cnt_raw !== 8'd0) begin n_fail++; $display("FAIL clr_cnt_raw got %0d want 0", cnt_raw); end
    endtask

    task automatic test_bounce();
        int e0;
        e0 = en_cycles;
        sw_in = 1'b1; step(2);
        sw_in = 1'b0; step(2);
        sw_in = 1'b1; step(2);
        sw_in = 1'b0; step(2);
        sw_in = 1'b1; step(20);
        n_checks++; if (cnt_raw !== 8'd3) begin n_fail++; $display("FAIL bounce_cnt_raw got %0d want 3", cnt_raw); end
        n_checks++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL bounce_cnt got %0d want 1", cnt); end
        n_checks++; if (en_cycles - e0 !== 1) begin n_fail++; $display("FAIL bounce_pulses got %0d want 1", en_cycles - e0); end
        n_checks++; if (sw_db !== 1'b1) begin n_fail++; $display("FAIL bounce_sw_db got %b want 1", sw_db); end
        sw_in = 1'b0;
        step(20);
        pulse_clr();
    endtask

    task automatic test_glitch();
        int e0;
        e0 = en_cycles;
        sw_in = 1'b1;
        step(6);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL glitch_chk_state got %0d want 1", state); end
        sw_in = 1'b0;
        step(20);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL glitch_state got %0d want 0", state); end
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL glitch_cnt got %0d want 0", cnt); end
        n_checks++; if (cnt_raw !== 8'd1) begin n_fail++; $display("FAIL glitch_cnt_raw got %0d want 1", cnt_raw); end
        n_checks++; if (en_cycles - e0 !== 0) begin n_fail++; $display("FAIL glitch_pulses got %0d want 0", en_cycles - e0); end
        n_checks++; if (sw_db !== 1'b0) begin n_fail++; $display("FAIL glitch_sw_db got %b want 0", sw_db); end
        pulse_clr();
    endtask

    task automatic test_wrap();
        int e0;
        e0 = en_cycles;
        for (int i = 0; i < 256; i++) begin
            sw_in = 1'b1; step(18);
            sw_in = 1'b0; step(18);
            if (i == 254) begin
                n_checks++; if (cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_cnt_255 got %0d want 255", cnt); end
            end
        end
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt got %0d want 0", cnt); end
        n_checks++; if (cnt_raw !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt_raw got %0d want 0", cnt_raw); end
        n_checks++; if (en_cycles - e0 !== 256) begin n_fail++; $display("FAIL wrap_pulses got %0d want 256", en_cycles - e0); end
    endtask

    task automatic test_clr_at_en();
        sw_in = 1'b1;
        step(1);
        step(13);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        n_checks++; if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL clren_cnt_en got %b want 1", cnt_en); end
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL clren_cnt got %0d want 0", cnt); end
        n_checks++; if (cnt_raw !== 8'd0) begin n_fail++; $display("FAIL clren_cnt_raw got %0d want 0", cnt_raw); end
        n_checks++; if (sw_db !== 1'b1) begin n_fail++; $display("FAIL clren_sw_db got %b want 1", sw_db); end
        step(1);
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL clren_cnt_next got %0d want 0", cnt); end
        n_checks++; if (sw_db !== 1'b1) begin n_fail++; $display("FAIL clren_sw_db_next got %b want 1", sw_db); end
        sw_in = 1'b0;
        step(20);
        pulse_clr();
    endtask

    task automatic test_reset_mid_chk();
        int e0;
        int lat;
        e0 = en_cycles;
        sw_in = 1'b1;
        step(1);
        step(11);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL rstchk_pre_state got %0d want 1", state); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rstchk_state got %0d want 0", state); end
        n_checks++; if (sw_db !== 1'b0) begin n_fail++; $display("FAIL rstchk_sw_db got %b want 0", sw_db); end
        n_checks++; if (cnt_raw !== 8'd0) begin n_fail++; $display("FAIL rstchk_cnt_raw got %0d want 0", cnt_raw); end
        step(4);
        n_checks++; if (en_cycles - e0 !== 0) begin n_fail++; $display("FAIL rstchk_no_pulse got %0d want 0", en_cycles - e0); end
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL rstchk_cnt_en got %b want 0", cnt_en); end
        rst_n = 1'b1;
        wait_en(lat);
        n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL rstchk_latency got %0d want 14", lat); end
        n_checks++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL rstchk_cnt got %0d want 1", cnt); end
        n_checks++; if (cnt_raw !== 8'd1) begin n_fail++; $display("FAIL rstchk_cnt_raw_after got %0d want 1", cnt_raw); end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_fall();
        test_bounce();
        test_glitch();
        test_wrap();
        test_clr_at_en();
        test_reset_mid_chk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
